// File: rtl/mt_pkg.sv
// Shared types and constants for the MT frame controller.
// Optional FMT validation is enabled by defining MTFC_FMT_CHECK_EN.
package mt_pkg;

    localparam logic [3:0] FMT_CORE_DUMP = 4'o0;
    localparam logic [3:0] FMT_NORMAL    = 4'o3;

    localparam logic [2:0] FPW_CORE_DUMP = 3'd5;
    localparam logic [2:0] FPW_NORMAL    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_EMIT,
        ST_DONE
    } mt_state_e;

    // Unknown formats fall back to core-dump framing.
    function automatic logic [2:0] fmt_fpw(input logic [3:0] fmt);
        return (fmt == FMT_NORMAL) ? FPW_NORMAL : FPW_CORE_DUMP;
    endfunction

    function automatic logic fmt_ok(input logic [3:0] fmt);
        return (fmt == FMT_CORE_DUMP) || (fmt == FMT_NORMAL);
    endfunction

endpackage

// File: rtl/mt_frame_gen.sv
// N-frame strobe generator: counts down the frames left in one word.
// done flags the last frame of the word.
module mt_frame_gen
    import mt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] n,
    input  logic       count,
    input  logic       abort,
    output logic       done
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (abort) begin
            cnt_d = 3'd0;
        end else if (load) begin
            cnt_d = n;
        end else if (count && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 3'd1);

endmodule

// File: rtl/mt_frame_ctrl.sv
// Tape frame controller: FC register, transfer FSM and frame strobes.
// Define MTFC_FMT_CHECK_EN to reject mtGO with an unsupported FMT.
module mt_frame_ctrl
    import mt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mtINIT,
    input  logic [35:0] mtDATAI,
    input  logic        mtWRFC,
    input  logic [15:0] mtTC,
    input  logic        mtGO,
    input  logic        mtWORD,
    output logic        mtWORDRDY,
    output logic        mtFRAME,
    output logic [15:0] mtFC,
    output logic        mtSETFCS,
    output logic        mtCLRFCS,
    output logic        mtBUSY,
    output logic        mtPGE
);

    mt_state_e   state_q, state_d;
    logic [15:0] fc_q, fc_d;
    logic        pge_q, pge_d;
    logic [2:0]  n_q, n_d;
    logic        setfcs_q, setfcs_d;
    logic        clrfcs_q, clrfcs_d;

    logic        gen_load;
    logic        gen_count;
    logic        gen_abort;
    logic        gen_done;
    logic        busy;
    logic [3:0]  fmt;
    logic        unused_bits;

    assign fmt         = mtTC[7:4];
    assign busy        = (state_q != ST_IDLE);
    assign unused_bits = ^{mtDATAI[35:16], mtTC[15:8], mtTC[3:0]};

    always_comb begin
        state_d   = state_q;
        fc_d      = fc_q;
        pge_d     = pge_q;
        n_d       = n_q;
        setfcs_d  = 1'b0;
        clrfcs_d  = 1'b0;
        gen_load  = 1'b0;
        gen_count = 1'b0;
        gen_abort = 1'b0;

        if (mtINIT) begin
            state_d   = ST_IDLE;
            fc_d      = 16'd0;
            pge_d     = 1'b0;
            gen_abort = 1'b1;
            clrfcs_d  = (state_q == ST_RUN) || (state_q == ST_EMIT);
        end else begin
            if (busy && (mtWRFC || mtGO)) begin
                pge_d = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (mtWRFC) begin
                        fc_d     = mtDATAI[15:0];
                        pge_d    = 1'b0;
                        setfcs_d = |mtDATAI[15:0];
                    end else if (mtGO) begin
`ifdef MTFC_FMT_CHECK_EN
                        if (fmt_ok(fmt)) begin
                            state_d = ST_RUN;
                        end else begin
                            pge_d = 1'b1;
                        end
`else
                        state_d = ST_RUN;
`endif
                    end
                end
                ST_RUN: begin
                    if (mtWORD) begin
                        n_d      = fmt_fpw(fmt);
                        gen_load = 1'b1;
                        state_d  = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    gen_count = 1'b1;
                    fc_d      = fc_q + 16'd1;
                    // Count exhausted: drop the rest of this word.
                    if (fc_q == 16'hFFFF) begin
                        state_d   = ST_DONE;
                        clrfcs_d  = 1'b1;
                        gen_abort = 1'b1;
                    end else if (gen_done) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            fc_q     <= 16'd0;
            pge_q    <= 1'b0;
            n_q      <= FPW_CORE_DUMP;
            setfcs_q <= 1'b0;
            clrfcs_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fc_q     <= fc_d;
            pge_q    <= pge_d;
            n_q      <= n_d;
            setfcs_q <= setfcs_d;
            clrfcs_q <= clrfcs_d;
        end
    end

    mt_frame_gen u_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (gen_load),
        .n     (n_d),
        .count (gen_count),
        .abort (gen_abort),
        .done  (gen_done)
    );

    assign mtWORDRDY = (state_q == ST_RUN);
    assign mtFRAME   = (state_q == ST_EMIT);
    assign mtFC      = fc_q;
    assign mtSETFCS  = setfcs_q;
    assign mtCLRFCS  = clrfcs_q;
    assign mtBUSY    = busy;
    assign mtPGE     = pge_q;

endmodule

// File: tb/tb_mt_frame_ctrl.sv
// Self-checking bench for mt_frame_ctrl: vector table, corner sequences
// and randomized transfers against a transaction-level model.
module tb_mt_frame_ctrl;

`ifdef MTFC_FMT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mtINIT;
    logic [35:0] mtDATAI;
    logic        mtWRFC;
    logic [15:0] mtTC;
    logic        mtGO;
    logic        mtWORD;
    logic        mtWORDRDY;
    logic        mtFRAME;
    logic [15:0] mtFC;
    logic        mtSETFCS;
    logic        mtCLRFCS;
    logic        mtBUSY;
    logic        mtPGE;

    int n_chk  = 0;
    int n_fail = 0;
    int frm_cnt = 0;
    int clr_cnt = 0;

    mt_frame_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mtINIT    (mtINIT),
        .mtDATAI   (mtDATAI),
        .mtWRFC    (mtWRFC),
        .mtTC      (mtTC),
        .mtGO      (mtGO),
        .mtWORD    (mtWORD),
        .mtWORDRDY (mtWORDRDY),
        .mtFRAME   (mtFRAME),
        .mtFC      (mtFC),
        .mtSETFCS  (mtSETFCS),
        .mtCLRFCS  (mtCLRFCS),
        .mtBUSY    (mtBUSY),
        .mtPGE     (mtPGE)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mtFRAME)  frm_cnt++;
        if (mtCLRFCS) clr_cnt++;
    end

    typedef struct {
        logic [15:0] fc;
        logic [3:0]  fmt;
        logic        exp_set;
        int          exp_frames;
        logic        exp_pge;
        logic        exp_done;
    } vec_t;

    vec_t vec[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrfc(input logic [15:0] d);
        mtDATAI = {20'h0, d};
        mtWRFC  = 1'b1;
        tick();
        mtWRFC  = 1'b0;
    endtask

    task automatic go();
        mtGO = 1'b1;
        tick();
        mtGO = 1'b0;
    endtask

    task automatic set_fmt(input logic [3:0] f);
        mtTC = {8'h00, f, 4'h0};
    endtask

    task automatic do_word(output int nf);
        int base;
        base   = frm_cnt;
        mtWORD = 1'b1;
        tick();
        mtWORD = 1'b0;
        for (int k = 0; k < 8 && mtFRAME; k++) tick();
        nf = frm_cnt - base;
    endtask

    task automatic init_pulse();
        mtINIT = 1'b1;
        tick();
        mtINIT = 1'b0;
    endtask

    initial begin
        int nf, cb, fb, rem, nper;
        logic [15:0] fcv, fc_exp;
        logic [3:0]  f;
        logic        valid, pge_exp;

        rst = 1'b0; mtINIT = 0; mtDATAI = '0; mtWRFC = 0;
        mtTC = '0; mtGO = 0; mtWORD = 0;
        #23;
        chk("rst_fc", mtFC, 0);
        chk("rst_outs", {mtWORDRDY, mtFRAME, mtSETFCS, mtCLRFCS, mtBUSY, mtPGE}, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_rdy", mtWORDRDY, 0);

        vec[0] = '{16'h0000, 4'o3, 1'b0, 4, 1'b0, 1'b0};
        vec[1] = '{16'o177777, 4'o0, 1'b1, 1, 1'b0, 1'b1};
        vec[2] = '{16'o177766, 4'o3, 1'b1, 4, 1'b0, 1'b0};
        vec[3] = '{16'h8000, 4'o0, 1'b1, 5, 1'b0, 1'b0};
        vec[4] = '{16'o177775, 4'o3, 1'b1, 3, 1'b0, 1'b1};
        vec[5] = '{16'hFF00, 4'o1, 1'b1, CHK ? 0 : 5, CHK, 1'b0};
        vec[6] = '{16'hFF00, 4'o17, 1'b1, CHK ? 0 : 5, CHK, 1'b0};

        foreach (vec[i]) begin
            wrfc(vec[i].fc);
            chk("tbl_fc", mtFC, vec[i].fc);
            chk("tbl_setfcs", mtSETFCS, vec[i].exp_set);
            tick();
            chk("tbl_setfcs_end", mtSETFCS, 0);
            set_fmt(vec[i].fmt);
            go();
            chk("tbl_go_pge", mtPGE, vec[i].exp_pge);
            chk("tbl_go_busy", mtBUSY, vec[i].exp_frames != 0);
            if (vec[i].exp_frames != 0) begin
                do_word(nf);
                chk("tbl_frames", nf, vec[i].exp_frames);
                fcv = vec[i].fc + 16'(nf);
                chk("tbl_fc_after", mtFC, fcv);
                chk("tbl_done", mtBUSY && !mtWORDRDY, vec[i].exp_done);
            end
            init_pulse();
            chk("tbl_init_idle", mtBUSY, 0);
            tick();
        end

        // -10 frames in normal format: 4 + 4 + 2
        cb = clr_cnt;
        wrfc(16'o177766);
        set_fmt(4'o3);
        go();
        do_word(nf);
        chk("w1_frames", nf, 4);
        chk("w1_fc", mtFC, 16'o177772);
        do_word(nf);
        chk("w2_frames", nf, 4);
        do_word(nf);
        chk("w3_frames", nf, 2);
        chk("w3_fc", mtFC, 0);
        chk("w3_done", {mtBUSY, mtWORDRDY, mtCLRFCS}, 3'b101);
        tick();
        chk("w3_idle", mtBUSY, 0);
        chk("w3_clr_once", clr_cnt - cb, 1);

        // Illegal writes while busy
        wrfc(16'o177774);
        go();
        wrfc(16'h1234);
        chk("pge_set", mtPGE, 1);
        chk("pge_fc_kept", mtFC, 16'o177774);
        chk("pge_no_set", mtSETFCS, 0);
        go();
        chk("pge_go_busy", mtPGE, 1);
        do_word(nf);
        chk("pge_frames", nf, 4);
        tick();
        chk("pge_sticky", {mtBUSY, mtPGE}, 2'b01);
        mtWORD = 1'b1;
        tick();
        mtWORD = 1'b0;
        chk("word_idle_ign", {mtBUSY, mtFRAME, mtPGE}, 3'b001);
        wrfc(16'd5);
        chk("pge_clr", mtPGE, 0);
        chk("pge_clr_fc", mtFC, 5);

        // WRFC wins over GO
        mtDATAI = 36'h0FFF0;
        mtWRFC = 1'b1; mtGO = 1'b1;
        tick();
        mtWRFC = 1'b0; mtGO = 1'b0;
        chk("prio_fc", mtFC, 16'hFFF0);
        chk("prio_busy", mtBUSY, 0);

        // INIT on frame 2 of 5
        cb = clr_cnt;
        wrfc(16'o177600);
        set_fmt(4'o0);
        go();
        mtWORD = 1'b1;
        tick();
        mtWORD = 1'b0;
        tick();
        chk("init_mid_emit", mtFRAME, 1);
        init_pulse();
        chk("init_state", {mtBUSY, mtFRAME, mtWORDRDY, mtCLRFCS}, 4'b0001);
        chk("init_fc", mtFC, 0);
        tick();
        chk("init_clr_once", clr_cnt - cb, 1);

        // Async reset mid-EMIT
        wrfc(16'o177600);
        go();
        mtWORD = 1'b1;
        tick();
        mtWORD = 1'b0;
        chk("ar_emit", mtFRAME, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_outs", {mtWORDRDY, mtFRAME, mtSETFCS, mtCLRFCS, mtBUSY}, 0);
        chk("ar_fc", mtFC, 0);
        #3 rst = 1'b1;
        tick(); tick();
        chk("ar_rdy_low", {mtWORDRDY, mtBUSY}, 0);
        go();
        chk("ar_rdy_go", mtWORDRDY, 1);
        init_pulse();
        tick();

        // Randomized transfers vs transaction model
        pge_exp = 1'b0;
        for (int t = 0; t < 40; t++) begin
            fcv = 16'(-$urandom_range(1, 23));
            f   = 4'($urandom_range(0, 15));
            wrfc(fcv);
            pge_exp = 1'b0;
            chk("rnd_fc", mtFC, fcv);
            chk("rnd_set", mtSETFCS, 1);
            if ($urandom_range(0, 3) == 0) begin
                mtWORD = 1'b1;
                tick();
                mtWORD = 1'b0;
                chk("rnd_word_idle", {mtBUSY, mtPGE}, 0);
            end
            set_fmt(f);
            go();
            valid = !CHK || f == 4'o0 || f == 4'o3;
            if (!valid) begin
                pge_exp = 1'b1;
                chk("rnd_rej", {mtBUSY, mtPGE}, 2'b01);
                continue;
            end
            chk("rnd_busy", mtBUSY, 1);
            nper   = (f == 4'o3) ? 4 : 5;
            rem    = 65536 - int'(fcv);
            fc_exp = fcv;
            cb     = clr_cnt;
            fb     = 0;
            while (rem > 0 && fb < 10) begin
                fb++;
                repeat ($urandom_range(0, 2)) tick();
                if ($urandom_range(0, 4) == 0) begin
                    wrfc(16'($urandom()));
                    pge_exp = 1'b1;
                    chk("rnd_ill_fc", mtFC, fc_exp);
                    chk("rnd_ill_pge", mtPGE, pge_exp);
                end
                do_word(nf);
                chk("rnd_frames", nf, (rem < nper) ? rem : nper);
                rem    = rem - nf;
                fc_exp = fc_exp + 16'(nf);
                chk("rnd_fc_run", mtFC, fc_exp);
            end
            tick();
            chk("rnd_end", {mtBUSY, mtPGE}, {1'b0, pge_exp});
            chk("rnd_fc0", mtFC, 0);
            chk("rnd_clr", clr_cnt - cb, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mt_frame_ctrl.md
MT_FRAME_CTRL -- requirements
Module: mt_frame_ctrl

Interface
REQ-001 SHALL have these ports: clk input 1, the single clock.
REQ-002 SHALL have these ports: rst input 1, reset, asynchronous and active-low.
REQ-003 SHALL have these ports: mtINIT input 1, MT initialize, synchronous clear.
REQ-004 SHALL have these ports: mtDATAI input 36, host write data; FC value is bits [15:0].
REQ-005 SHALL have these ports: mtWRFC input 1, frame count register write strobe.
REQ-006 SHALL have these ports: mtTC input 16, tape control register; format field FMT is [7:4].
REQ-007 SHALL have these ports: mtGO input 1, start-transfer pulse.
REQ-008 SHALL have these ports: mtWORD input 1, 36-bit word valid strobe.
REQ-009 SHALL have these ports: mtWORDRDY output 1, ready to accept mtWORD.
REQ-010 SHALL have these ports: mtFRAME output 1, one-cycle strobe per tape frame.
REQ-011 SHALL have these ports: mtFC output 16, current frame count.
REQ-012 SHALL have these ports: mtSETFCS output 1, one-cycle pulse that sets TC FCS.
REQ-013 SHALL have these ports: mtCLRFCS output 1, one-cycle pulse that clears TC FCS.
REQ-014 SHALL have these ports: mtBUSY output 1, transfer in progress.
REQ-015 SHALL have these ports: mtPGE output 1, sticky program error.

Function
REQ-016 SHALL hold FC as a two's-complement negative count; each frame increments it by 1.
REQ-017 SHALL load mtDATAI[15:0] into FC on mtWRFC while idle; when the loaded value is nonzero, SHALL pulse mtSETFCS on the following cycle.
REQ-018 SHALL implement states IDLE, RUN, EMIT and DONE.
REQ-019 SHALL treat mtGO in IDLE as IDLE->RUN with mtBUSY=1; FC=0 at mtGO means 65536 frames.
REQ-020 SHALL assert mtWORDRDY only in RUN; mtWORD in RUN latches frames-per-word N and moves to EMIT.
REQ-021 SHALL set N=5 for FMT=4'o0 (core dump) and N=4 for FMT=4'o3 (normal 10-core).
REQ-022 SHALL, in EMIT, assert mtFRAME on N consecutive cycles, each incrementing FC, then return to RUN.
REQ-023 SHALL, when FC wraps to 0, go to DONE on the same edge, discard the remaining frames of the word, and pulse mtCLRFCS.
REQ-024 SHALL hold DONE for one cycle, then go to IDLE with mtBUSY=0.
REQ-025 SHALL, for mtWRFC or mtGO while mtBUSY=1: ignore it, set mtPGE, and leave FC unchanged.
REQ-026 SHALL ignore mtWORD outside RUN and raise no error for it.
REQ-027 SHALL give mtWRFC priority over mtGO when both are asserted in IDLE; mtGO is then ignored.
REQ-028 SHALL, on mtINIT in any state, go to IDLE and clear FC, mtPGE and all strobes next cycle.
REQ-029 SHALL, on mtINIT mid-transfer, pulse mtCLRFCS once.
REQ-030 SHALL clear mtPGE only on rst, mtINIT, or a legal mtWRFC.

Reset
REQ-031 SHALL, on rst low, asynchronously set state=IDLE, FC=0, mtPGE=0 and N=5.
REQ-032 SHALL hold all of mtWORDRDY, mtFRAME, mtSETFCS, mtCLRFCS and mtBUSY at 0 during reset.
REQ-033 SHALL have no rst deassertion side effects; the first active edge is the first clk edge after rst goes high.

Configuration
REQ-034 SHALL, with MTFC_FMT_CHECK_EN defined: treat mtGO with an FMT other than 4'o0 or 4'o3 as not starting, set mtPGE, and stay in IDLE.
REQ-035 SHALL, with MTFC_FMT_CHECK_EN undefined: treat unsupported FMT values as N=5 with no error.

Structure
REQ-036 SHALL put in shared package mt_pkg: FMT constants (FMT_CORE_DUMP=4'o0, FMT_NORMAL=4'o3), the frames-per-word constants (5 and 4), and the state enum type.
REQ-037 SHALL contain one sub-module, mt_frame_gen: N-frame strobe generator with load, count and abort inputs and a done output.

Verification
REQ-038 SHALL cover: FC=16'o177766 (-10), FMT=3, mtGO, 3 words -> 10 mtFRAME strobes; FC=0 after frame 10; third word emits only 2 frames; one mtCLRFCS.
REQ-039 SHALL cover: mtWRFC with 0 -> no mtSETFCS; mtWRFC with 16'o177777 -> mtSETFCS one cycle later; FMT=0 word -> 1 frame then DONE.
REQ-040 SHALL cover: mtWRFC during RUN -> mtPGE=1 and mtFC unchanged; a later legal mtWRFC -> mtPGE=0.
REQ-041 SHALL cover: mtINIT during EMIT (frame 2 of 5) -> next cycle IDLE, FC=0, mtBUSY=0, one mtCLRFCS.
REQ-042 SHALL cover: rst low mid-EMIT -> outputs 0 immediately (asynchronous); after release mtWORDRDY=0 until mtGO.
REQ-043 SHALL cover: FMT=4'o1 with mtGO -> with MTFC_FMT_CHECK_EN, mtPGE=1 and IDLE; without it, 5 frames per word.
